imm_gen_pipe: RTL
=================

# imm_gen_pipe

Pipelined, parametrised immediate generator with a valid/ready handshake. It sits between fetch/decode and the execute stage. It takes a full 32-bit instruction word plus a format select and returns the sign- or zero-extended immediate, XLEN bits wide, one cycle later. A 2-entry skid buffer keeps throughput at one instruction per cycle under downstream back-pressure. Format errors are flagged rather than silently zeroed.

## Interface
- XLEN, 32: immediate/output width; legal values 32 or 64.
- TAG_W, 32: width of sideband tag (typically PC) carried alongside each instruction.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; discards all buffered entries.
- in_valid  input  1  instruction offered.
- in_ready  output  1  block can accept; registered.
- in_instr  input  32  raw instruction word.
- in_sel  input  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SHAMT, 110 CSR, 111 reserved.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts.
- out_imm  output  XLEN  extended immediate.
- out_err  output  1  illegal format/encoding for this entry.
- out_tag  output  TAG_W  tag matching out_imm.

## Operation
- The input transfer occurs when in_valid && in_ready. The output transfer occurs when out_valid && out_ready.
- Formats (s = instr[31], sign-extended to XLEN):
  - I: {s, instr[30:20]}.
  - S: {s, instr[30:25], instr[11:7]}.
  - B: {s, instr[7], instr[30:25], instr[11:8], 0}.
  - J: {s, instr[19:12], instr[20], instr[30:21], 0}.
  - U: {s, instr[30:12], 12'b0}. Sign extension applies only when XLEN=64.
- SHAMT: zero-extended instr[25:20] when XLEN=64. When XLEN=32 it is zero-extended instr[24:20], and instr[25]=1 sets out_err.
- CSR: zero-extended instr[19:15] (zimm). Availability depends on configuration.
- 111, or any format that is disabled: out_imm=0, out_err=1. The entry is still delivered and is never dropped.
- Storage is an output register (main) plus one skid register. Entries are delivered in order. Decode happens before storage, so both registers hold final results.
- in_ready = !skid_valid, registered.
- State machine, encoded by (main_valid, skid_valid):
  - EMPTY (0,0) → ONE on accept.
  - ONE (1,0): accept with no drain → FULL. Drain with no accept → EMPTY. Accept and drain together → stay in ONE, and main loads the new entry.
  - FULL (1,1): drain → ONE, and skid moves to main. No accept is possible in FULL.
- flush: the next state is EMPTY and any concurrent accept is discarded. Flush has priority over all other events.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N with out_valid=1.
- Sustained throughput is 1 entry per cycle while out_ready=1.
- out_ready falling with a continuous input stream: at most one extra entry is absorbed (into skid). in_ready drops the following cycle.
- in_ready rises in the cycle after skid drains.
- out_* stay stable while out_valid && !out_ready.
- Reset values (asynchronous, immediate on rst_n=0):
  - out_valid=0, out_imm=0, out_err=0, out_tag=0.
  - skid cleared.
  - in_ready=1.
- Reset mid-operation discards all entries. Operation resumes on the first edge after rst_n returns high.
- After flush, out_valid=0 and in_ready=1 from the next cycle.

## Configuration
- IMM_GEN_CSR_EN defined: the CSR format (110) is decoded as zimm, with out_err=0.
- IMM_GEN_CSR_EN undefined: 110 is treated as reserved, giving out_imm=0 and out_err=1. The zimm mux leg is not synthesised.

## Test plan
- XLEN=32, out_ready=1, back-to-back inputs:
  - I 0xFFF00093 → 0xFFFFFFFF.
  - S 0xFE20AE23 → 0xFFFFFFFC.
  - J 0xFFDFF06F → 0xFFFFFFFC.
  - U 0x123450B7 → 0x12345000.
  - Each result appears one cycle after its input, tags match, out_err=0.
- XLEN=64:
  - SHAMT 0x02109093 (slli x1,x1,33) → 33, out_err=0.
  - U 0x800000B7 → 0xFFFFFFFF80000000.
  - XLEN=32, same SHAMT word → out_err=1.
- Back-pressure: stream 4 entries with out_ready=0 from cycle 1 → main and skid fill, in_ready=0 from cycle 3, outputs hold steady. Release out_ready → all 4 delivered in order with no loss or duplication.
- in_sel=111, and in_sel=110 with IMM_GEN_CSR_EN undefined → out_imm=0, out_err=1. With the macro defined, CSR 0x3E5FD073 (zimm=31) → 31, out_err=0.
- flush asserted in FULL together with in_valid → next cycle out_valid=0, in_ready=1, and the flushed entry and concurrent input never appear.
- rst_n pulled low while FULL, asynchronous to clk → all outputs at reset values immediately. The first post-reset input is delivered with 1-cycle latency.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a two-entry (main + skid) valid/ready buffer.
// Optional CSR zimm decode is enabled by defining IMM_GEN_CSR_EN.
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag
);

   logic [63:0]      imm_wide;
   logic [XLEN-1:0]  dec_imm;
   logic             dec_err;
   logic             sgn;

   logic             main_valid_q, main_valid_d;
   logic [XLEN-1:0]  main_imm_q, main_imm_d;
   logic             main_err_q, main_err_d;
   logic [TAG_W-1:0] main_tag_q, main_tag_d;
   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
   logic             skid_err_q, skid_err_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
   logic             in_ready_q, in_ready_d;

   logic             accept;
   logic             drain;

   assign sgn = in_instr[31];

   // Decode at full 64-bit width, then keep the low XLEN bits.
   always_comb begin
      imm_wide = '0;
      dec_err  = 1'b0;
      case (in_sel)
         3'b000: imm_wide = {{52{sgn}}, in_instr[31:20]};
         3'b001: imm_wide = {{52{sgn}}, in_instr[31:25], in_instr[11:7]};
         3'b010: imm_wide = {{51{sgn}}, in_instr[31], in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
         3'b011: imm_wide = {{43{sgn}}, in_instr[31], in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
         3'b100: imm_wide = {{32{sgn}}, in_instr[31:12], 12'b0};
         3'b101: begin
            if (XLEN == 64) begin
               imm_wide = {58'b0, in_instr[25:20]};
            end else begin
               imm_wide = {59'b0, in_instr[24:20]};
               dec_err  = in_instr[25];
            end
         end
`ifdef IMM_GEN_CSR_EN
         3'b110: imm_wide = {59'b0, in_instr[19:15]};
`endif
         default: begin
            imm_wide = '0;
            dec_err  = 1'b1;
         end
      endcase
   end

   assign dec_imm = imm_wide[XLEN-1:0];

   if (XLEN < 64) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^imm_wide[63:XLEN];
   end

   logic unused_opcode;
   assign unused_opcode = ^in_instr[6:0];

   assign accept = in_valid & in_ready_q;
   assign drain  = main_valid_q & out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_imm_d   = main_imm_q;
      main_err_d   = main_err_q;
      main_tag_d   = main_tag_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_err_d   = skid_err_q;
      skid_tag_d   = skid_tag_q;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (drain) begin
         if (skid_valid_q) begin
            main_imm_d   = skid_imm_q;
            main_err_d   = skid_err_q;
            main_tag_d   = skid_tag_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_imm_d = dec_imm;
            main_err_d = dec_err;
            main_tag_d = in_tag;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_valid_q) begin
            main_valid_d = 1'b1;
            main_imm_d   = dec_imm;
            main_err_d   = dec_err;
            main_tag_d   = in_tag;
         end else begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_err_d   = dec_err;
            skid_tag_d   = in_tag;
         end
      end

      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_imm_q   <= '0;
         main_err_q   <= 1'b0;
         main_tag_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_err_q   <= 1'b0;
         skid_tag_q   <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_imm_q   <= main_imm_d;
         main_err_q   <= main_err_d;
         main_tag_q   <= main_tag_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_err_q   <= skid_err_d;
         skid_tag_q   <= skid_tag_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign out_imm   = main_imm_q;
   assign out_err   = main_err_q;
   assign out_tag   = main_tag_q;

endmodule
